// File: rtl/tcp_client.sv
// Active-open TCP connection controller. It sends SYN, waits for a matching
// SYN-ACK (retransmitting on timeout), completes the handshake with ACK and
// tracks the connection until it is closed by abort, a peer RST or a timeout.
//
// state       | meaning
// ------------+---------------------------------------------------------
// CLOSED      | idle, waiting for open_i
// SEND_SYN    | SYN presented to the assembler, waiting for tx_ready_i
// SYN_SENT    | waiting for SYN-ACK, retransmit timer running
// SEND_ACK    | ACK presented to the assembler, waiting for tx_ready_i
// ESTABLISHED | connection open
// SEND_RST    | RST presented to the assembler, waiting for tx_ready_i
module tcp_client #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        open_i,
  input  logic        abort_i,
  input  logic [31:0] iss_i,
  input  logic        rx_valid_i,
  input  logic [5:0]  rx_flags_i,
  input  logic [31:0] rx_seq_i,
  input  logic [31:0] rx_ack_i,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [5:0]  tx_flags_o,
  output logic [31:0] tx_seq_o,
  output logic [31:0] tx_ack_o,
  output logic        established_o,
  output logic [31:0] snd_nxt_o,
  output logic [31:0] rcv_nxt_o,
  output logic        timeout_o,
  output logic        reset_rx_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  localparam logic [5:0] F_SYN = 6'h02;
  localparam logic [5:0] F_ACK = 6'h10;
  localparam logic [5:0] F_RST = 6'h04;

  typedef enum logic [2:0] {
    CLOSED, SEND_SYN, SYN_SENT, SEND_ACK, ESTABLISHED, SEND_RST
  } state_t;

  state_t        state;
  logic [31:0]   iss;
  logic [31:0]   irs;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry_cnt;
  logic          abort_pend;

  logic [31:0] iss_p1;
  logic        rx_synack;
  logic        rx_rstack;
  logic        rx_rst_est;

  // Segment classification against the current ISS/IRS
  assign iss_p1     = iss + 32'd1;
  assign rx_synack  = rx_valid_i && rx_flags_i[1] && rx_flags_i[4] && !rx_flags_i[2]
                      && (rx_ack_i == iss_p1);
  assign rx_rstack  = rx_valid_i && rx_flags_i[2] && rx_flags_i[4] && (rx_ack_i == iss_p1);
  assign rx_rst_est = rx_valid_i && rx_flags_i[2] && (rx_seq_i == irs + 32'd1);

  // Connection FSM with registered tx request, status and pulse outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= CLOSED;
      iss           <= '0;
      irs           <= '0;
      timer         <= '0;
      retry_cnt     <= '0;
      abort_pend    <= 1'b0;
      tx_valid_o    <= 1'b0;
      tx_flags_o    <= '0;
      tx_seq_o      <= '0;
      tx_ack_o      <= '0;
      established_o <= 1'b0;
      snd_nxt_o     <= '0;
      rcv_nxt_o     <= '0;
      timeout_o     <= 1'b0;
      reset_rx_o    <= 1'b0;
    end else begin
      timeout_o  <= 1'b0;
      reset_rx_o <= 1'b0;
      case (state)
        CLOSED: begin
          if (open_i) begin
            state      <= SEND_SYN;
            iss        <= iss_i;
            retry_cnt  <= '0;
            abort_pend <= 1'b0;
            tx_valid_o <= 1'b1;
            tx_flags_o <= F_SYN;
            tx_seq_o   <= iss_i;
            tx_ack_o   <= '0;
            snd_nxt_o  <= iss_i;
            rcv_nxt_o  <= '0;
          end
        end

        SEND_SYN: begin
          if (abort_i) abort_pend <= 1'b1;
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            tx_flags_o <= '0;
            tx_seq_o   <= '0;
            if (abort_pend || abort_i) begin
              state      <= CLOSED;
              abort_pend <= 1'b0;
              snd_nxt_o  <= '0;
            end else begin
              state <= SYN_SENT;
              timer <= TIMER_LOAD;
            end
          end
        end

        SYN_SENT: begin
          // A valid SYN-ACK wins over a simultaneous timer expiry
          if (abort_i) begin
            state     <= CLOSED;
            snd_nxt_o <= '0;
          end else if (rx_synack) begin
            state      <= SEND_ACK;
            irs        <= rx_seq_i;
            tx_valid_o <= 1'b1;
            tx_flags_o <= F_ACK;
            tx_seq_o   <= iss_p1;
            tx_ack_o   <= rx_seq_i + 32'd1;
            snd_nxt_o  <= iss_p1;
            rcv_nxt_o  <= rx_seq_i + 32'd1;
          end else if (rx_rstack) begin
            state      <= CLOSED;
            reset_rx_o <= 1'b1;
            snd_nxt_o  <= '0;
          end else if (timer == '0) begin
            if (retry_cnt == RETRY_MAX) begin
              state     <= CLOSED;
              timeout_o <= 1'b1;
              snd_nxt_o <= '0;
            end else begin
              state      <= SEND_SYN;
              retry_cnt  <= retry_cnt + 1'b1;
              tx_valid_o <= 1'b1;
              tx_flags_o <= F_SYN;
              tx_seq_o   <= iss;
              tx_ack_o   <= '0;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        SEND_ACK: begin
          if (abort_i) abort_pend <= 1'b1;
          if (tx_ready_i) begin
            if (abort_pend || abort_i) begin
              // Back-to-back request: the RST follows the accepted ACK
              state      <= SEND_RST;
              abort_pend <= 1'b0;
              tx_flags_o <= F_RST;
              tx_seq_o   <= iss_p1;
              tx_ack_o   <= '0;
            end else begin
              state         <= ESTABLISHED;
              established_o <= 1'b1;
              tx_valid_o    <= 1'b0;
              tx_flags_o    <= '0;
              tx_seq_o      <= '0;
              tx_ack_o      <= '0;
            end
          end
        end

        ESTABLISHED: begin
          if (abort_i) begin
            state         <= SEND_RST;
            established_o <= 1'b0;
            tx_valid_o    <= 1'b1;
            tx_flags_o    <= F_RST;
            tx_seq_o      <= iss_p1;
            tx_ack_o      <= '0;
          end else if (rx_rst_est) begin
            state         <= CLOSED;
            established_o <= 1'b0;
            reset_rx_o    <= 1'b1;
            snd_nxt_o     <= '0;
            rcv_nxt_o     <= '0;
          end else if (rx_synack) begin
            // Our ACK was lost; resend it with the IRS already captured
            state         <= SEND_ACK;
            established_o <= 1'b0;
            tx_valid_o    <= 1'b1;
            tx_flags_o    <= F_ACK;
            tx_seq_o      <= iss_p1;
            tx_ack_o      <= irs + 32'd1;
          end
        end

        SEND_RST: begin
          if (tx_ready_i) begin
            state      <= CLOSED;
            tx_valid_o <= 1'b0;
            tx_flags_o <= '0;
            tx_seq_o   <= '0;
            tx_ack_o   <= '0;
            snd_nxt_o  <= '0;
            rcv_nxt_o  <= '0;
          end
        end

        default: begin
          state         <= CLOSED;
          tx_valid_o    <= 1'b0;
          established_o <= 1'b0;
          snd_nxt_o     <= '0;
          rcv_nxt_o     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_client.sv
// Directed bench for tcp_client: handshake, retransmit/timeout, bad and
// late SYN-ACKs, sequence wrap, backpressure, abort, peer RST and reset.
module tb_tcp_client;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        open_i;
  logic        abort_i;
  logic [31:0] iss_i;
  logic        rx_valid_i;
  logic [5:0]  rx_flags_i;
  logic [31:0] rx_seq_i;
  logic [31:0] rx_ack_i;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [5:0]  tx_flags_o;
  logic [31:0] tx_seq_o;
  logic [31:0] tx_ack_o;
  logic        established_o;
  logic [31:0] snd_nxt_o;
  logic [31:0] rcv_nxt_o;
  logic        timeout_o;
  logic        reset_rx_o;

  int tests_run = 0;
  int tests_failed = 0;

  tcp_client #(.TIMEOUT_CYCLES(16), .MAX_RETRIES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .open_i(open_i), .abort_i(abort_i), .iss_i(iss_i),
    .rx_valid_i(rx_valid_i), .rx_flags_i(rx_flags_i), .rx_seq_i(rx_seq_i), .rx_ack_i(rx_ack_i),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_flags_o(tx_flags_o),
    .tx_seq_o(tx_seq_o), .tx_ack_o(tx_ack_o), .established_o(established_o),
    .snd_nxt_o(snd_nxt_o), .rcv_nxt_o(rcv_nxt_o), .timeout_o(timeout_o), .reset_rx_o(reset_rx_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_rx(input logic [5:0] flags, input logic [31:0] seq, input logic [31:0] ack);
    rx_valid_i = 1'b1;
    rx_flags_i = flags;
    rx_seq_i   = seq;
    rx_ack_i   = ack;
    tick();
    rx_valid_i = 1'b0;
    rx_flags_i = '0;
    rx_seq_i   = '0;
    rx_ack_i   = '0;
  endtask

  int syn_cyc[$];
  int to_cyc;
  int to_cnt;

  initial begin
    rst_i = 1'b1; open_i = 1'b0; abort_i = 1'b0; iss_i = '0;
    rx_valid_i = 1'b0; rx_flags_i = '0; rx_seq_i = '0; rx_ack_i = '0; tx_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("reset_established", 32'(established_o), 32'd0);
    chk("reset_snd_nxt", snd_nxt_o, 32'd0);
    chk("reset_rcv_nxt", rcv_nxt_o, 32'd0);
    chk("reset_pulses", {30'd0, timeout_o, reset_rx_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // Basic handshake, then peer RST
    tx_ready_i = 1'b1; iss_i = 32'h1000; open_i = 1'b1;
    tick();
    open_i = 1'b0;
    chk("syn_valid", 32'(tx_valid_o), 32'd1);
    chk("syn_flags", 32'(tx_flags_o), 32'h02);
    chk("syn_seq", tx_seq_o, 32'h1000);
    chk("syn_ack", tx_ack_o, 32'h0);
    chk("syn_snd_nxt", snd_nxt_o, 32'h1000);
    tick();
    chk("syn_sent_valid", 32'(tx_valid_o), 32'd0);
    send_rx(6'h12, 32'h5000, 32'h1001);
    chk("ack_valid", 32'(tx_valid_o), 32'd1);
    chk("ack_flags", 32'(tx_flags_o), 32'h10);
    chk("ack_seq", tx_seq_o, 32'h1001);
    chk("ack_ack", tx_ack_o, 32'h5001);
    chk("ack_snd_nxt", snd_nxt_o, 32'h1001);
    tick();
    chk("est_established", 32'(established_o), 32'd1);
    chk("est_rcv_nxt", rcv_nxt_o, 32'h5001);
    chk("est_tx_valid", 32'(tx_valid_o), 32'd0);
    send_rx(6'h04, 32'h5002, 32'h0);
    chk("bad_rst_ignored", 32'(established_o), 32'd1);
    send_rx(6'h04, 32'h5001, 32'h0);
    chk("peer_rst_pulse", 32'(reset_rx_o), 32'd1);
    chk("peer_rst_closed", 32'(established_o), 32'd0);
    chk("peer_rst_snd_nxt", snd_nxt_o, 32'd0);
    chk("peer_rst_rcv_nxt", rcv_nxt_o, 32'd0);
    tick();
    chk("peer_rst_pulse_end", 32'(reset_rx_o), 32'd0);

    // No response: 3 SYNs, then timeout
    iss_i = 32'h2000; open_i = 1'b1;
    tick();
    open_i = 1'b0;
    syn_cyc.delete();
    to_cyc = -1; to_cnt = 0;
    if (tx_valid_o) syn_cyc.push_back(0);
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (tx_valid_o) begin
        syn_cyc.push_back(c);
        chk("retx_seq", tx_seq_o, 32'h2000);
        chk("retx_flags", 32'(tx_flags_o), 32'h02);
      end
      if (timeout_o) begin
        to_cnt++;
        if (to_cyc < 0) to_cyc = c;
      end
    end
    chk("retx_count", 32'(syn_cyc.size()), 32'd3);
    chk("retx_first", (syn_cyc.size() > 0) ? 32'(syn_cyc[0]) : 32'hFFFF_FFFF, 32'd0);
    chk("retx_second", (syn_cyc.size() > 1) ? 32'(syn_cyc[1]) : 32'hFFFF_FFFF, 32'd17);
    chk("retx_third", (syn_cyc.size() > 2) ? 32'(syn_cyc[2]) : 32'hFFFF_FFFF, 32'd34);
    chk("timeout_cycle", 32'(to_cyc), 32'd51);
    chk("timeout_pulses", 32'(to_cnt), 32'd1);
    chk("timeout_closed", snd_nxt_o, 32'd0);

    // Wrong-ack SYN-ACK ignored, correct one on the expiry cycle wins
    iss_i = 32'h3000; open_i = 1'b1;
    tick();
    open_i = 1'b0;
    tick();
    iss_i = 32'hDEAD; open_i = 1'b1;
    send_rx(6'h12, 32'h7000, 32'h3002);
    open_i = 1'b0;
    chk("bad_synack_valid", 32'(tx_valid_o), 32'd0);
    chk("bad_synack_snd_nxt", snd_nxt_o, 32'h3000);
    chk("bad_synack_rcv_nxt", rcv_nxt_o, 32'd0);
    repeat (14) tick();
    chk("pre_expiry_idle", 32'(tx_valid_o), 32'd0);
    send_rx(6'h12, 32'h7000, 32'h3001);
    chk("late_synack_flags", 32'(tx_flags_o), 32'h10);
    chk("late_synack_seq", tx_seq_o, 32'h3001);
    chk("late_synack_ack", tx_ack_o, 32'h7001);
    tick();
    chk("late_est", 32'(established_o), 32'd1);

    // Duplicate SYN-ACK re-sends ACK with the original IRS
    send_rx(6'h12, 32'h9999, 32'h3001);
    chk("dup_synack_flags", 32'(tx_flags_o), 32'h10);
    chk("dup_synack_ack", tx_ack_o, 32'h7001);
    tick();
    chk("dup_synack_est", 32'(established_o), 32'd1);

    // Local abort from ESTABLISHED
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_rst_valid", 32'(tx_valid_o), 32'd1);
    chk("abort_rst_flags", 32'(tx_flags_o), 32'h04);
    chk("abort_rst_seq", tx_seq_o, 32'h3001);
    chk("abort_rst_ack", tx_ack_o, 32'h0);
    chk("abort_est_low", 32'(established_o), 32'd0);
    tick();
    chk("abort_closed_valid", 32'(tx_valid_o), 32'd0);
    chk("abort_closed_snd", snd_nxt_o, 32'd0);

    // Abort while SYN is stalled: closes after the SYN is taken
    tx_ready_i = 1'b0; iss_i = 32'h4000; open_i = 1'b1;
    tick();
    open_i = 1'b0; abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("pend_syn_held", 32'(tx_valid_o), 32'd1);
    tx_ready_i = 1'b1;
    tick();
    chk("pend_closed_valid", 32'(tx_valid_o), 32'd0);
    chk("pend_closed_snd", snd_nxt_o, 32'd0);

    // Sequence wrap and backpressure stability
    tx_ready_i = 1'b0; iss_i = 32'hFFFF_FFFF; open_i = 1'b1;
    tick();
    open_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wrap_syn_stable", {tx_valid_o, 1'b0, tx_flags_o, tx_ack_o[23:0]}, 32'h8200_0000);
      chk("wrap_syn_seq", tx_seq_o, 32'hFFFF_FFFF);
    end
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
    send_rx(6'h12, 32'h0100, 32'h0000_0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wrap_ack_stable", {tx_valid_o, 1'b0, tx_flags_o, 24'd0}, 32'h9000_0000);
      chk("wrap_ack_seq", tx_seq_o, 32'h0000_0000);
      chk("wrap_ack_ack", tx_ack_o, 32'h0000_0101);
    end
    chk("wrap_snd_nxt", snd_nxt_o, 32'h0000_0000);

    // Asynchronous reset mid-handshake
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_valid", 32'(tx_valid_o), 32'd0);
    chk("async_rst_est", 32'(established_o), 32'd0);
    chk("async_rst_rcv", rcv_nxt_o, 32'd0);
    #2 rst_i = 1'b0;
    tick();
    chk("post_rst_idle", 32'(tx_valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
